// File: rtl/seq_mult_ctrl.sv
// -----------------------------------------------------------------------------
// seq_mult_ctrl
// Sequencing controller and shift-add datapath for a signed sequential
// multiplier. The block accepts two two's-complement operands on a start/ready
// handshake and converts them to magnitudes. It runs one unsigned add/shift
// iteration per clock, then applies the result sign (XOR of the operand MSBs)
// and presents the signed product together with a one-cycle done pulse.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous, active-low reset
//   start        request a multiplication (sampled only while ready=1)
//   multiplicand signed operand A, sampled on the accepting edge
//   multiplier   signed operand B, sampled on the accepting edge
//   ready        high only in IDLE
//   busy         high in RUN and SIGN
//   done         registered one-cycle pulse marking a new product
//   product      signed 2*WORD_LENGTH result, held until the next result
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for start; operands are captured on the accepting edge
// RUN   | one add/shift iteration per clock, WORD_LENGTH cycles in total
// SIGN  | apply the sign to the magnitude, write product, raise done
// DONE  | drop done, return to IDLE; product holds
// -----------------------------------------------------------------------------
module seq_mult_ctrl #(
   parameter int WORD_LENGTH = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic [WORD_LENGTH-1:0]     multiplicand,
   input  logic [WORD_LENGTH-1:0]     multiplier,
   output logic                       ready,
   output logic                       busy,
   output logic                       done,
   output logic [2*WORD_LENGTH-1:0]   product
);

   localparam int COUNT_WIDTH = $clog2(WORD_LENGTH) + 1;
   localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = COUNT_WIDTH'(1);
   localparam logic [COUNT_WIDTH-1:0] CNT_LAST = COUNT_WIDTH'(WORD_LENGTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      SIGN = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t                     state;
   logic [WORD_LENGTH-1:0]     mcand_mag;
   logic [WORD_LENGTH-1:0]     mplier_mag;
   logic [WORD_LENGTH-1:0]     acc;
   logic                       neg;
   logic [COUNT_WIDTH-1:0]     counter;

   logic [WORD_LENGTH-1:0]     mcand_abs;
   logic [WORD_LENGTH-1:0]     mplier_abs;
   logic [WORD_LENGTH-1:0]     addend;
   logic [WORD_LENGTH:0]       sum;
   logic [2*WORD_LENGTH-1:0]   mag;

   // The most negative operand negates to itself in WORD_LENGTH bits, which
   // read as unsigned is exactly its magnitude 2^(WORD_LENGTH-1).
   always_comb begin
      mcand_abs  = multiplicand[WORD_LENGTH-1] ? -multiplicand : multiplicand;
      mplier_abs = multiplier[WORD_LENGTH-1]   ? -multiplier   : multiplier;
      addend     = mplier_mag[0] ? mcand_mag : '0;
      sum        = {1'b0, acc} + {1'b0, addend};
      // After the last shift the low half of the product sits in mplier_mag.
      mag        = {acc, mplier_mag};
   end

   assign ready = (state == IDLE);
   assign busy  = (state == RUN) || (state == SIGN);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         mcand_mag  <= '0;
         mplier_mag <= '0;
         acc        <= '0;
         neg        <= 1'b0;
         counter    <= '0;
         product    <= '0;
         done       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  mcand_mag  <= mcand_abs;
                  mplier_mag <= mplier_abs;
                  neg        <= multiplicand[WORD_LENGTH-1] ^ multiplier[WORD_LENGTH-1];
                  acc        <= '0;
                  counter    <= '0;
                  state      <= RUN;
               end
            end
            RUN: begin
               done <= 1'b0;
               // {carry, acc, mplier_mag} shifted right by one.
               acc        <= sum[WORD_LENGTH:1];
               mplier_mag <= {sum[0], mplier_mag[WORD_LENGTH-1:1]};
               counter    <= counter + CNT_ONE;
               if (counter == CNT_LAST) begin
                  state <= SIGN;
               end
            end
            SIGN: begin
               // Negating a zero magnitude yields zero, so no negative zero.
               product <= neg ? -mag : mag;
               done    <= 1'b1;
               state   <= DONE;
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_mult_ctrl.sv
module tb_seq_mult_ctrl;

   logic        clk;
   logic        reset;
   logic        start;
   logic [7:0]  multiplicand;
   logic [7:0]  multiplier;
   logic        ready;
   logic        busy;
   logic        done;
   logic [15:0] product;

   int tests = 0;
   int fails = 0;

   seq_mult_ctrl #(.WORD_LENGTH(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .ready        (ready),
      .busy         (busy),
      .done         (done),
      .product      (product)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Single run: accept at edge 0, done expected on edge 9, ready on edge 10.
   task automatic do_mult(input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] exp, input string nm);
      int  edge_n;
      bit  seen;
      @(negedge clk);
      start = 1'b1; multiplicand = a; multiplier = b;
      @(posedge clk); #1;
      tests++;
      if (ready !== 1'b0 || busy !== 1'b1) begin
         fails++;
         $display("FAIL %s accept: ready=%b busy=%b, required ready=0 busy=1", nm, ready, busy);
      end
      @(negedge clk);
      start = 1'b0; multiplicand = 8'h55; multiplier = 8'hAA;
      edge_n = 0; seen = 1'b0;
      while (!seen && edge_n < 20) begin
         @(posedge clk); #1;
         edge_n++;
         if (done === 1'b1) seen = 1'b1;
      end
      tests++;
      if (!seen || edge_n != 9) begin
         fails++;
         $display("FAIL %s done_edge: seen=%0b edge=%0d, required edge=9", nm, seen, edge_n);
      end
      tests++;
      if (product !== exp) begin
         fails++;
         $display("FAIL %s product: got %h, required %h", nm, product, exp);
      end
      @(posedge clk); #1;
      tests++;
      if (done !== 1'b0 || ready !== 1'b1 || product !== exp) begin
         fails++;
         $display("FAIL %s after_done: done=%b ready=%b product=%h, required done=0 ready=1 product=%h",
                  nm, done, ready, product, exp);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; start = 1'b0; multiplicand = 8'h00; multiplier = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      tests++;
      if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || product !== 16'h0000) begin
         fails++;
         $display("FAIL reset_state: ready=%b busy=%b done=%b product=%h, required 1 0 0 0000",
                  ready, busy, done, product);
      end
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      tests++;
      if (ready !== 1'b1 || busy !== 1'b0) begin
         fails++;
         $display("FAIL reset_release: ready=%b busy=%b, required ready=1 busy=0", ready, busy);
      end
   endtask

   task automatic test_basic();
      do_mult(8'd3, 8'd5, 16'h000F, "3x5");
   endtask

   task automatic test_signs();
      do_mult(8'hFD, 8'd5,  16'hFFF1, "m3x5");
      do_mult(8'd5,  8'hFD, 16'hFFF1, "5xm3");
      do_mult(8'hF9, 8'hFA, 16'h002A, "m7xm6");
   endtask

   task automatic test_corners();
      do_mult(8'h80, 8'h80, 16'h4000, "m128xm128");
      do_mult(8'h80, 8'h7F, 16'hC080, "m128x127");
      do_mult(8'h7F, 8'h7F, 16'h3F01, "127x127");
   endtask

   task automatic test_zero();
      do_mult(8'h00, 8'hF9, 16'h0000, "0xm7");
   endtask

   task automatic test_ignore_start();
      int pulses;
      int done_edge;
      pulses = 0; done_edge = -1;
      @(negedge clk);
      start = 1'b1; multiplicand = 8'd3; multiplier = 8'd5;
      @(posedge clk); #1;
      for (int i = 1; i <= 16; i++) begin
         @(negedge clk);
         if (i == 3) begin
            start = 1'b1; multiplicand = 8'd7; multiplier = 8'd9;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         if (done === 1'b1) begin
            pulses++;
            done_edge = i;
         end
      end
      tests++;
      if (pulses != 1 || done_edge != 9) begin
         fails++;
         $display("FAIL ignore_start pulses: got %0d at edge %0d, required 1 at edge 9", pulses, done_edge);
      end
      tests++;
      if (product !== 16'h000F) begin
         fails++;
         $display("FAIL ignore_start product: got %h, required 000F", product);
      end
      tests++;
      if (ready !== 1'b1 || busy !== 1'b0) begin
         fails++;
         $display("FAIL ignore_start idle: ready=%b busy=%b, required ready=1 busy=0", ready, busy);
      end
   endtask

   task automatic test_back_to_back();
      int pulses;
      int e1;
      int e2;
      logic [15:0] p1;
      pulses = 0; e1 = -1; e2 = -1; p1 = '0;
      @(negedge clk);
      start = 1'b1; multiplicand = 8'd2; multiplier = 8'd3;
      @(posedge clk); #1;
      @(negedge clk);
      multiplicand = 8'hFC; multiplier = 8'd5;
      for (int i = 1; i <= 21; i++) begin
         @(posedge clk); #1;
         if (done === 1'b1) begin
            pulses++;
            if (pulses == 1) begin
               e1 = i; p1 = product;
            end else begin
               e2 = i;
            end
         end
      end
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      tests++;
      if (pulses != 2 || e1 != 9 || e2 != 20) begin
         fails++;
         $display("FAIL b2b timing: pulses=%0d e1=%0d e2=%0d, required 2 at 9 and 20", pulses, e1, e2);
      end
      tests++;
      if (p1 !== 16'h0006) begin
         fails++;
         $display("FAIL b2b first: got %h, required 0006", p1);
      end
      tests++;
      if (product !== 16'hFFEC || ready !== 1'b1) begin
         fails++;
         $display("FAIL b2b second: product=%h ready=%b, required FFEC ready=1", product, ready);
      end
   endtask

   task automatic test_reset_mid_run();
      int pulses;
      pulses = 0;
      @(negedge clk);
      start = 1'b1; multiplicand = 8'd3; multiplier = 8'd5;
      @(posedge clk); #1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      tests++;
      if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || product !== 16'h0000) begin
         fails++;
         $display("FAIL reset_mid: ready=%b busy=%b done=%b product=%h, required 1 0 0 0000",
                  ready, busy, done, product);
      end
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 14; i++) begin
         @(posedge clk); #1;
         if (done === 1'b1) pulses++;
      end
      tests++;
      if (pulses != 0 || product !== 16'h0000 || ready !== 1'b1) begin
         fails++;
         $display("FAIL reset_mid aftermath: pulses=%0d product=%h ready=%b, required 0 0000 1",
                  pulses, product, ready);
      end
      do_mult(8'd2, 8'd2, 16'h0004, "2x2");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_signs();
      test_corners();
      test_zero();
      test_ignore_start();
      test_back_to_back();
      test_reset_mid_run();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/seq_mult_ctrl.md
Name: seq_mult_ctrl

Overview:
- Sequencing controller and shift-add datapath for the signed sequential multiplier.
- Accepts two two's-complement operands on a start/ready handshake, converts them to magnitudes, and records the result sign as the XOR of the operand MSBs (same rule as the sign unit).
- Runs one add/shift iteration per clock, applies the sign to the magnitude product, and presents the signed product with a one-cycle done pulse.
- Sits between the operand source (switch/register front end) and the result display/consumer.

Parameters:
- WORD_LENGTH, 8, operand width in bits; the product is 2*WORD_LENGTH bits.
- COUNT_WIDTH, $clog2(WORD_LENGTH)+1, iteration counter width; derived, never overridden.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request a multiplication; sampled only while ready=1.
- multiplicand  input  WORD_LENGTH  signed operand A; sampled on the accepting edge.
- multiplier  input  WORD_LENGTH  signed operand B; sampled on the accepting edge.
- ready  output  1  high only in IDLE (decoded from state).
- busy  output  1  high in RUN and SIGN.
- done  output  1  registered one-cycle pulse marking a new product.
- product  output  2*WORD_LENGTH  signed result; holds until the next result is written.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, product=0, done=0, counter=0, all internal operand, accumulator and sign registers cleared. ready=1 and busy=0 while in reset. Reset asserted mid-operation aborts the run immediately, and no done pulse is produced for it.
- States: IDLE, RUN, SIGN, DONE.
  - IDLE: on a rising edge with start=1:
    - mcand_mag <= |multiplicand| and mplier_mag <= |multiplier|, both unsigned, WORD_LENGTH bits. The most negative value maps to 2^(WORD_LENGTH-1), which fits unsigned.
    - neg <= multiplicand[MSB] ^ multiplier[MSB].
    - acc <= 0, counter <= 0, next state RUN.
    - start=0 keeps the block in IDLE.
  - RUN: every edge:
    - If mplier_mag[0]=1, add mcand_mag to the upper half of acc, with a WORD_LENGTH+1-bit sum including carry.
    - Shift {carry, acc, mplier_mag} right by one. Result: a standard unsigned shift-add, 2*WORD_LENGTH-bit magnitude.
    - counter increments. When counter reaches WORD_LENGTH-1, the iteration in progress is the last and the next state is SIGN.
    - Exactly WORD_LENGTH RUN cycles.
  - SIGN: product <= neg ? (~mag + 1) : mag, done <= 1, next state DONE.
  - DONE: done <= 0, next state IDLE; product holds.
- Latency: the accepting edge is edge 0. Product and done update on edge WORD_LENGTH+1, and done is high for exactly one cycle after it. ready returns high after edge WORD_LENGTH+2. Accept-to-accept throughput is WORD_LENGTH+3 cycles.
- start while not IDLE: ignored. Operands are not resampled and the run in progress is unaffected.
- start held high continuously: a new operation is accepted on the first edge in IDLE, i.e. back-to-back runs.
- Operand input changes after the accepting edge: no effect.
- Zero operand: product=0 regardless of neg; two's-complement negation of 0 is 0, so no negative zero exists.
- Range: the full signed range is exact. For WORD_LENGTH=8, (-128)*(-128)=+16384 and (-128)*127=-16256, both within 16-bit signed. No overflow is possible and none is flagged.
- product changes only on the SIGN edge or reset.

Test Plan:
- reset then 3*5 with a single start pulse at edge 0 → ready drops after edge 0; done=1 for exactly one cycle after edge 9 (WORD_LENGTH=8); product=16'h000F; ready high again after edge 10.
- (-3)*5 and 5*(-3) → product=16'hFFF1 (-15) in both cases; (-7)*(-6) → 16'h002A (+42).
- (-128)*(-128) → 16'h4000; (-128)*127 → 16'hC080; 127*127 → 16'h3F01.
- 0*(-7) → 16'h0000, with done pulsed once.
- start re-pulsed at edge 3 with different operands during a 3*5 run → result still 16'h000F; only one done pulse; no second run starts.
- reset asserted at edge 4 of a run → product=0, done never pulses, ready=1 immediately. After release, 2*2 completes with product=16'h0004.
